// File: rtl/mux9_scan_sequencer_pkg.sv
// Shared types and constants for the 9:1 mux scan sequencer.
// The settle counter width bounds the settle interval to 0..15 cycles.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } scan_state_t;

  localparam int DEF_NUM_INPUTS = 9;
  localparam int DEF_SEL_W      = 4;
  localparam int SETTLE_W       = 4;

  // True when the given select addresses the final mux input of a scan.
  function automatic logic is_last_sel(input logic [DEF_SEL_W-1:0] sel,
                                       input int num_inputs);
    return (sel == DEF_SEL_W'(num_inputs - 1));
  endfunction

endpackage

// File: rtl/mux9_scan_sequencer_if.sv
// Mux-side and consumer-side signals of the scan sequencer.
// The sequencer uses the slave modport; the surrounding logic uses master.
interface mux9_scan_sequencer_if #(
  parameter int NUM_INPUTS = mux_scan_pkg::DEF_NUM_INPUTS,
  parameter int SEL_W      = mux_scan_pkg::DEF_SEL_W
);

  logic                  start;
  logic [SEL_W-1:0]      sel;
  logic                  mux_out;
  logic [NUM_INPUTS-1:0] data_out;
  logic                  data_valid;
  logic                  data_ready;
  logic                  busy;

  modport slave (
    input  start,
    input  mux_out,
    input  data_ready,
    output sel,
    output data_out,
    output data_valid,
    output busy
  );

  modport master (
    output start,
    output mux_out,
    output data_ready,
    input  sel,
    input  data_out,
    input  data_valid,
    input  busy
  );

endinterface

// File: rtl/mux9_scan_sequencer_settle_timer.sv
// Loadable settle down-counter; expire is a registered flag that is high
// exactly while the count sits at 1, i.e. during the last settle cycle.
module mux9_settle_timer #(
  parameter int W = mux_scan_pkg::SETTLE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] count_r;
  logic [W-1:0] count_nxt_s;
  logic         expire_r;

  // Next count: load wins, otherwise count down and rest at zero.
  always_comb begin
    count_nxt_s = count_r;
    if (load) begin
      count_nxt_s = load_val;
    end else if (count_r != {W{1'b0}}) begin
      count_nxt_s = count_r - W'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Counter and expire flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r  <= {W{1'b0}};
      expire_r <= 1'b0;
    end else begin
      count_r  <= count_nxt_s;
      expire_r <= (count_nxt_s == W'(1));
    end
  end

  assign expire = expire_r;

endmodule

// File: rtl/mux9_scan_sequencer.sv
// Steps a 9:1 mux select through every input, samples each after a settle
// interval, and hands the packed word downstream on valid/ready.
module mux9_scan_sequencer #(
  parameter int NUM_INPUTS = mux_scan_pkg::DEF_NUM_INPUTS,
  parameter int SEL_W      = mux_scan_pkg::DEF_SEL_W,
  parameter int SETTLE_CYC = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mux9_scan_sequencer_if.slave   bus
);

  import mux_scan_pkg::*;

  localparam logic [SETTLE_W-1:0] SETTLE_VAL = SETTLE_W'(SETTLE_CYC);
  localparam logic [SEL_W-1:0]    LAST_SEL   = SEL_W'(NUM_INPUTS - 1);
  localparam bit                  NO_SETTLE  = (SETTLE_CYC == 0);

  scan_state_t           state_r;
  logic [SEL_W-1:0]      sel_r;
  logic [NUM_INPUTS-1:0] data_r;
  logic                  valid_r;
  logic                  busy_r;
  logic                  tmr_load_s;
  logic                  tmr_expire_s;
  logic                  last_s;

  assign last_s = (sel_r == LAST_SEL);

  // Timer is (re)armed whenever a settle interval begins.
  always_comb begin
    tmr_load_s = 1'b0;
    case (state_r)
      IDLE:    tmr_load_s = bus.start;
      SAMPLE:  tmr_load_s = !last_s;
      default: tmr_load_s = 1'b0;
    endcase
  end

  mux9_settle_timer #(.W(SETTLE_W)) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load_s),
    .load_val (SETTLE_VAL),
    .expire   (tmr_expire_s)
  );

  // Scan FSM with select, capture word, valid and busy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      sel_r   <= {SEL_W{1'b0}};
      data_r  <= {NUM_INPUTS{1'b0}};
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            data_r  <= {NUM_INPUTS{1'b0}};
            sel_r   <= {SEL_W{1'b0}};
            busy_r  <= 1'b1;
            state_r <= NO_SETTLE ? SAMPLE : SETTLE;
          end
        end
        SETTLE: begin
          if (tmr_expire_s) begin
            state_r <= SAMPLE;
          end
        end
        SAMPLE: begin
          for (int i = 0; i < NUM_INPUTS; i++) begin
            if (sel_r == SEL_W'(i)) begin
              data_r[i] <= bus.mux_out;
            end
          end
          if (last_s) begin
            valid_r <= 1'b1;
            state_r <= DONE;
          end else begin
            sel_r   <= sel_r + SEL_W'(1);
            state_r <= NO_SETTLE ? SAMPLE : SETTLE;
          end
        end
        DONE: begin
          // Start is deliberately not looked at here, even on the handshake cycle.
          if (bus.data_ready) begin
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.sel        = sel_r;
  assign bus.data_out   = data_r;
  assign bus.data_valid = valid_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_mux9_scan_sequencer.sv
// Three sequencers (settle 1, 0, 3) on shared stimulus, each checked every
// cycle against an elapsed-time model, plus literal word and latency checks.
module tb_mux9_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       ready = 1'b1;
  logic [8:0] mux_in = 9'h000;

  int total = 0;
  int bad = 0;

  logic [3:0] sel_o [3];
  logic [8:0] dout_o [3];
  logic       vld_o [3];
  logic       busy_o [3];

  always #5 clk = ~clk;

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
  endfunction

  genvar g;
  for (g = 0; g < 3; g++) begin : g_dut
    localparam int S = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    mux9_scan_sequencer_if bus ();
    assign bus.start      = start;
    assign bus.data_ready = ready;
    assign bus.mux_out    = (bus.sel < 4'd9) ? mux_in[bus.sel] : 1'b0;
    assign sel_o[g]       = bus.sel;
    assign dout_o[g]      = bus.data_out;
    assign vld_o[g]       = bus.data_valid;
    assign busy_o[g]      = bus.busy;
    mux9_scan_sequencer #(.SETTLE_CYC(S)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  task automatic check(input string name, input int inst,
                       input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h at %0t", name, inst, act, exp, $time);
    end
  endtask

  // Model: a scan is "elapsed cycles since start"; everything follows from it.
  int         m_e [3];
  bit         m_act [3];
  bit         m_vld [3];
  logic [8:0] m_dout [3];
  logic [3:0] m_sel [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_e[i] = 0; m_act[i] = 0; m_vld[i] = 0; m_dout[i] = 9'h000; m_sel[i] = 4'd0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        automatic int p = settle_of(i) + 1;
        automatic int cur;
        if (m_vld[i]) begin
          if (ready) m_vld[i] = 0;
        end else if (m_act[i]) begin
          cur = m_e[i] / p;
          m_e[i]++;
          if (m_e[i] % p == 0) m_dout[i][cur] = mux_in[cur];
          if (m_e[i] == 9 * p) begin
            m_act[i] = 0;
            m_vld[i] = 1;
          end
          m_sel[i] = ((m_e[i] / p) > 8) ? 4'd8 : 4'(m_e[i] / p);
        end else if (start) begin
          m_act[i] = 1; m_e[i] = 0; m_dout[i] = 9'h000; m_sel[i] = 4'd0;
        end
      end
    end
  end

  // Per-cycle comparison of every DUT against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        check("sel", i, 16'(sel_o[i]), 16'(m_sel[i]));
        check("data_out", i, 16'(dout_o[i]), 16'(m_dout[i]));
        check("data_valid", i, 16'(vld_o[i]), 16'(m_vld[i]));
        check("busy", i, 16'(busy_o[i]), 16'(m_act[i] | m_vld[i]));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    ready = 1'b1;
    while ((busy_o[0] | busy_o[1] | busy_o[2]) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 0, 16'(n >= 200), 16'd0);
  endtask

  task automatic scan_and_check(input logic [8:0] pat);
    int lat [3];
    logic [8:0] word [3];
    int exp_lat [3];
    exp_lat = '{18, 9, 36};
    wait_idle();
    mux_in = pat;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    for (int i = 0; i < 3; i++) begin lat[i] = -1; word[i] = 9'h000; end
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (lat[i] < 0 && vld_o[i]) begin
          lat[i]  = n;
          word[i] = dout_o[i];
        end
      end
      if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      check("latency", i, 16'(lat[i]), 16'(exp_lat[i]));
      check("word", i, 16'(word[i]), 16'(pat));
    end
  endtask

  initial begin
    int n;
    logic [8:0] pat;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_sel", i, 16'(sel_o[i]), 16'd0);
      check("rst_data", i, 16'(dout_o[i]), 16'd0);
      check("rst_valid", i, 16'(vld_o[i]), 16'd0);
      check("rst_busy", i, 16'(busy_o[i]), 16'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    scan_and_check(9'h155);
    scan_and_check(9'h1F6);
    scan_and_check(9'h11F);

    // Backpressure: word held, start ignored in DONE and on the handshake cycle.
    wait_idle();
    pat = 9'h0A7;
    mux_in = pat;
    ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!vld_o[0] && n < 60) begin @(negedge clk); n++; end
    check("bp_timeout", 0, 16'(n >= 60), 16'd0);
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 0, 16'(vld_o[0]), 16'd1);
      check("bp_data", 0, 16'(dout_o[0]), 16'(pat));
      start = (c == 2);
      @(negedge clk);
    end
    ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("bp_busy", 0, 16'(busy_o[0]), 16'd0);
    check("bp_valid_drop", 0, 16'(vld_o[0]), 16'd0);

    // Reset mid-scan at sel=4, between clock edges.
    wait_idle();
    mux_in = 9'h1FF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (sel_o[0] != 4'd4 && n < 60) begin @(negedge clk); n++; end
    check("sel4_timeout", 0, 16'(n >= 60), 16'd0);
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("abort_sel", i, 16'(sel_o[i]), 16'd0);
      check("abort_data", i, 16'(dout_o[i]), 16'd0);
      check("abort_valid", i, 16'(vld_o[i]), 16'd0);
      check("abort_busy", i, 16'(busy_o[i]), 16'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    scan_and_check(9'h0C3);

    // Random traffic, checked cycle by cycle against the model.
    for (int c = 0; c < 1500; c++) begin
      start = ($urandom_range(0, 7) == 0);
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) mux_in = 9'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();
    scan_and_check(9'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
